// File: rtl/demap_buf_sched_if.sv
// Bus bundle between the demapper bit buffer scheduler and its surroundings:
// configuration/start, upstream bit handshake, RAM strobes and burst status.
interface demap_buf_sched_if #(
    parameter int AD = 14,
    parameter int NW = 9
);
    logic          start;
    logic [NW-1:0] cfg_ncbps;
    logic          in_valid;
    logic          in_ready;
    logic          out_ready;
    logic          ram_we;
    logic          ram_re;
    logic [AD-1:0] wr_addr;
    logic [AD-1:0] rd_addr;
    logic          out_valid;
    logic          out_first;
    logic          out_last;
    logic [AD:0]   occupancy;
    logic          busy;
    logic          overflow;
    logic          cfg_err;

    modport master (
        output start, cfg_ncbps, in_valid, out_ready,
        input  in_ready, ram_we, ram_re, wr_addr, rd_addr, out_valid,
               out_first, out_last, occupancy, busy, overflow, cfg_err
    );

    modport slave (
        input  start, cfg_ncbps, in_valid, out_ready,
        output in_ready, ram_we, ram_re, wr_addr, rd_addr, out_valid,
               out_first, out_last, occupancy, busy, overflow, cfg_err
    );
endinterface

// File: rtl/demap_buf_sched.sv
// Circular bit buffer controller: accepts demapped bits into a RAM and releases
// them downstream in uninterrupted bursts of one OFDM symbol (cfg_ncbps bits).
module demap_buf_sched #(
    parameter int AD = 14,
    parameter int NW = 9
) (
    input  logic               clk,
    input  logic               reset,
    demap_buf_sched_if.slave   bus
);
    localparam int DEPTH = 2 ** AD;
    localparam int OW    = AD + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

    state_t        state_q, state_d;
    logic [AD-1:0] wr_addr_q, wr_addr_d;
    logic [AD-1:0] rd_addr_q, rd_addr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic [OW-1:0] ncbps_q, ncbps_d;
    logic [OW-1:0] rem_q, rem_d;
    logic          first_q, first_d;
    logic          overflow_q, overflow_d;
    logic          cfg_err_q, cfg_err_d;
    logic          out_valid_q, out_valid_d;
    logic          out_first_q, out_first_d;
    logic          out_last_q, out_last_d;

    logic          in_ready;
    logic          we;
    logic          re;
    logic          last_rd;
    logic          cfg_ok;
    logic [31:0]   cfg_val;

    // occupancy never exceeds DEPTH, so its top bit alone means "full"
    assign in_ready = (state_q != S_IDLE) && !occ_q[AD];
    assign we       = bus.in_valid && in_ready;
    assign re       = (state_q == S_BURST);
    assign last_rd  = re && (rem_q == OW'(1));
    assign cfg_val  = 32'(bus.cfg_ncbps);
    assign cfg_ok   = (cfg_val != 32'd0) && (cfg_val <= 32'(DEPTH));

    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q + AD'(we);
        rd_addr_d   = rd_addr_q + AD'(re);
        occ_d       = occ_q;
        ncbps_d     = ncbps_q;
        rem_d       = rem_q;
        first_d     = first_q;
        overflow_d  = overflow_q || (bus.in_valid && !in_ready && (state_q != S_IDLE));
        cfg_err_d   = cfg_err_q;
        out_valid_d = re;
        out_first_d = re && first_q;
        out_last_d  = last_rd;

        case ({we, re})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase

        case (state_q)
            S_WAIT: begin
                if ((occ_q >= ncbps_q) && bus.out_ready) begin
                    state_d = S_BURST;
                    rem_d   = ncbps_q;
                    first_d = 1'b1;
                end
            end
            S_BURST: begin
                first_d = 1'b0;
                rem_d   = rem_q - OW'(1);
                if (rem_q == OW'(1)) begin
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // start restarts the frame from any state and wins over everything above
        if (bus.start) begin
            state_d     = cfg_ok ? S_WAIT : S_IDLE;
            wr_addr_d   = '0;
            rd_addr_d   = '0;
            occ_d       = '0;
            ncbps_d     = cfg_ok ? OW'(bus.cfg_ncbps) : '0;
            rem_d       = '0;
            first_d     = 1'b0;
            overflow_d  = 1'b0;
            cfg_err_d   = !cfg_ok;
            out_valid_d = 1'b0;
            out_first_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            occ_q       <= '0;
            ncbps_q     <= '0;
            rem_q       <= '0;
            first_q     <= 1'b0;
            overflow_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            occ_q       <= occ_d;
            ncbps_q     <= ncbps_d;
            rem_q       <= rem_d;
            first_q     <= first_d;
            overflow_q  <= overflow_d;
            cfg_err_q   <= cfg_err_d;
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.ram_we    = we;
    assign bus.ram_re    = re;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_first = out_first_q;
    assign bus.out_last  = out_last_q;
    assign bus.occupancy = occ_q;
    assign bus.busy      = re;
    assign bus.overflow  = overflow_q;
    assign bus.cfg_err   = cfg_err_q;
endmodule
